// File: rtl/result_serializer_6x32_pkg.sv
// Shared vector geometry for the adder-tree bank and the result serializer.
//
// Contents:
//   LANES, WORD_W  : six 32-bit float lanes per result vector
//   VEC_W          : full result vector width (192)
//   LANE_W, lane_t : lane index width and type
//   LAST_LANE      : index of the final lane in a vector
//   lane_word()    : picks one 32-bit lane out of a result vector
package result_serializer_6x32_pkg;

   localparam int LANES  = 6;
   localparam int WORD_W = 32;
   localparam int VEC_W  = LANES * WORD_W;
   localparam int LANE_W = $clog2(LANES);

   typedef logic [LANE_W-1:0] lane_t;

   localparam lane_t LAST_LANE = lane_t'(LANES - 1);

   // A mux written as a loop over constant slices, so the selected lane
   // never needs a variable part-select multiply.
   function automatic logic [WORD_W-1:0] lane_word(input logic [VEC_W-1:0] vec,
                                                   input lane_t           lane);
      lane_word = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane == lane_t'(k)) begin
            lane_word = vec[k*WORD_W +: WORD_W];
         end
      end
   endfunction

endpackage

// File: rtl/result_serializer_6x32_fifo.sv
// Wide synchronous FIFO used as the result-vector buffer.
//
// The caller is responsible for never pushing into a full FIFO unless it
// pops in the same cycle, and never popping an empty one. clear flushes
// the pointers and occupancy and overrides push/pop in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
//
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : synchronous flush
//   push      : write wdata at the tail
//   pop       : retire the head entry
//   wdata     : entry to write
//   rdata     : current head entry (combinational read)
//   count     : occupancy, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
module sync_fifo_wide #(
   parameter int WIDTH = 192,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
   // the occupancy unchanged, which is what lets a full FIFO accept a new
   // entry on the same cycle it retires the head.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; nothing reads an entry before it is written.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wptr] <= wdata;
      end
   end

   assign rdata = mem[rptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == CW'(0));

endmodule

// File: rtl/result_serializer_6x32.sv
// Result serializer behind the 6x6 adder-tree bank.
//
// Buffers each 192-bit result vector in a wide FIFO and streams it out as
// six 32-bit AXI-Stream beats, lane 0 first. tlast marks the final beat of
// every FRAME_LEN-th vector. The tree cannot stall, so in_ready is only an
// early almost-full hint; a push that finds the FIFO full (and no pop) is
// dropped and latches the sticky overflow flag.
//
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   clear            : synchronous flush of FIFO, counters and flags
//   in_valid/in_data : one-cycle result pulse and its 192-bit vector
//   in_ready         : high while occupancy is below DEPTH-AFULL_MARGIN
//   m_axis_*         : 32-bit AXI-Stream master toward the DMA
//   count            : FIFO occupancy
//   overflow         : sticky dropped-push flag
module result_serializer_6x32
   import result_serializer_6x32_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int AFULL_MARGIN = 4,
   parameter int FRAME_LEN    = 64
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [VEC_W-1:0]       in_data,
   output logic                   in_ready,
   output logic [WORD_W-1:0]      m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   lane_t            lane;
   logic [FW-1:0]    frame_cnt;
   logic [VEC_W-1:0] head;
   logic             full;
   logic             empty;
   logic             fire;
   logic             pop;
   logic             push;
   logic             frame_end;

   // The head entry retires on the beat that carries its last lane. clear
   // overrides both directions so a flushed cycle moves nothing.
   assign m_axis_tvalid = !empty;
   assign fire          = m_axis_tvalid && m_axis_tready;
   assign pop           = fire && (lane == LAST_LANE) && !clear;
   assign push          = in_valid && !clear && (!full || pop);

   // Data and tlast are forced low while nothing is queued so the stream
   // is quiet out of reset and after a flush.
   assign frame_end     = (frame_cnt == FW'(FRAME_LEN - 1));
   assign m_axis_tdata  = m_axis_tvalid ? lane_word(head, lane) : '0;
   assign m_axis_tlast  = m_axis_tvalid && (lane == LAST_LANE) && frame_end;
   assign in_ready      = (count < CW'(DEPTH - AFULL_MARGIN));

   sync_fifo_wide #(
      .WIDTH (VEC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Lane and frame position of the head entry. The lane only moves on an
   // accepted beat, which keeps tdata/tlast stable under backpressure; the
   // frame counter moves once per retired vector and wraps after the
   // vector that carried tlast.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lane      <= '0;
         frame_cnt <= '0;
      end else if (clear) begin
         lane      <= '0;
         frame_cnt <= '0;
      end else if (fire) begin
         if (lane == LAST_LANE) begin
            lane      <= '0;
            frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
         end else begin
            lane <= lane + lane_t'(1);
         end
      end
   end

   // Sticky drop flag: a result arriving while the buffer is full and the
   // head is not retiring this cycle is lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
      end else if (in_valid && !push) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_result_serializer_6x32.sv
// Self-checking bench for result_serializer_6x32 (DEPTH=16, AFULL_MARGIN=4,
// FRAME_LEN=3). The reference model is a queue of expected output beats:
// every accepted vector appends six beats, and the n-th vector since the
// last flush carries tlast on its final beat when n mod FRAME_LEN is
// FRAME_LEN-1.
module tb_result_serializer_6x32;
   import result_serializer_6x32_pkg::*;

   localparam int DEPTH        = 16;
   localparam int AFULL_MARGIN = 4;
   localparam int FRAME_LEN    = 3;
   localparam int CW           = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rstn;
   logic              clear;
   logic              in_valid;
   logic [VEC_W-1:0]  in_data;
   logic              in_ready;
   logic [WORD_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic [CW-1:0]     count;
   logic              overflow;

   result_serializer_6x32 #(
      .DEPTH        (DEPTH),
      .AFULL_MARGIN (AFULL_MARGIN),
      .FRAME_LEN    (FRAME_LEN)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .clear         (clear),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .count         (count),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          lane;
      bit          last;
   } beat_t;

   beat_t beats[$];
   int    vec_idx;
   bit    m_ovf;
   int    checks;
   int    errors;

   // Model state is dropped wholesale on reset or flush.
   task automatic m_reset();
      beats.delete();
      vec_idx = 0;
      m_ovf   = 1'b0;
   endtask

   // Entries held = vectors with at least one beat still owed.
   function automatic int m_count();
      return (beats.size() + LANES - 1) / LANES;
   endfunction

   // Packed expected outputs {tvalid, tlast, tdata, count, in_ready, overflow}.
   function automatic logic [40:0] exp_outs();
      logic          v;
      logic [CW-1:0] c;
      int            n;
      n = m_count();
      v = (beats.size() != 0);
      c = CW'(n);
      return {v, v ? beats[0].last : 1'b0, v ? beats[0].data : 32'h0,
              c, (n < DEPTH - AFULL_MARGIN), m_ovf};
   endfunction

   // DUT outputs in the same layout; tdata/tlast only matter while valid is expected.
   function automatic logic [40:0] act_outs(input logic v);
      return {m_axis_tvalid, v ? m_axis_tlast : 1'b0, v ? m_axis_tdata : 32'h0,
              count, in_ready, overflow};
   endfunction

   function automatic logic [VEC_W-1:0] rand_vec();
      logic [VEC_W-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*WORD_W +: WORD_W] = $urandom();
      return v;
   endfunction

   // Advance one rising edge and apply the driven inputs to the model,
   // then return at the following falling edge.
   task automatic step();
      int n;
      bit v, fire, pop, push;
      @(posedge clk);
      n    = m_count();
      v    = (beats.size() != 0);
      fire = v && m_axis_tready;
      pop  = 1'b0;
      if (fire) pop = (beats[0].lane == LANES - 1);
      if (clear) begin
         m_reset();
      end else begin
         push = in_valid && ((n < DEPTH) || pop);
         if (fire) void'(beats.pop_front());
         if (push) begin
            for (int k = 0; k < LANES; k++) begin
               beats.push_back('{data: in_data[k*WORD_W +: WORD_W], lane: k,
                                 last: (k == LANES - 1) && ((vec_idx % FRAME_LEN) == FRAME_LEN - 1)});
            end
            vec_idx++;
         end else if (in_valid) begin
            m_ovf = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic flush();
      clear = 1'b1;
      in_valid = 1'b0;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
      m_reset();
      #23;
      checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset count: got %0d expected 0", count); end
      checks++; if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin errors++; $display("[TB] FAIL reset tvalid/tlast: got %b expected 00", {m_axis_tvalid, m_axis_tlast}); end
      checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset tdata: got %h expected 0", m_axis_tdata); end
      checks++; if ({in_ready, overflow} !== 2'b10) begin errors++; $display("[TB] FAIL reset in_ready/overflow: got %b expected 10", {in_ready, overflow}); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] lanes [LANES];
      logic [40:0] e, a;
      lanes = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
      for (int k = 0; k < LANES; k++) in_data[k*WORD_W +: WORD_W] = lanes[k];
      in_valid = 1'b1; m_axis_tready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL single model beat %0d: got %h expected %h", i, a, e); end
         checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {2'b10, lanes[i]}) begin
            errors++; $display("[TB] FAIL single beat %0d: got v%b l%b %h expected v1 l0 %h", i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, lanes[i]);
         end
         step();
      end
      checks++; if ({m_axis_tvalid, count} !== {1'b0, CW'(0)}) begin errors++; $display("[TB] FAIL single drained: got v%b count %0d expected v0 count 0", m_axis_tvalid, count); end
   endtask

   task automatic test_backpressure();
      logic [40:0] e, a;
      logic [31:0] pdata;
      logic        plast, pvalid, pready;
      int          fires;
      in_valid = 1'b1; in_data = rand_vec(); m_axis_tready = 1'b0;
      step();
      in_valid = 1'b0; fires = 0; pvalid = 1'b0; pready = 1'b1; pdata = '0; plast = 1'b0;
      for (int cyc = 0; cyc < 40 && beats.size() != 0; cyc++) begin
         m_axis_tready = cyc[0];
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL backpressure cyc %0d: got %h expected %h", cyc, a, e); end
         if (pvalid && !pready) begin
            checks++; if ({m_axis_tdata, m_axis_tlast} !== {pdata, plast}) begin
               errors++; $display("[TB] FAIL backpressure hold cyc %0d: got %h/%b expected %h/%b", cyc, m_axis_tdata, m_axis_tlast, pdata, plast);
            end
         end
         if (m_axis_tvalid && m_axis_tready) fires++;
         pvalid = m_axis_tvalid; pready = m_axis_tready; pdata = m_axis_tdata; plast = m_axis_tlast;
         step();
      end
      checks++; if (fires != LANES || count !== '0) begin errors++; $display("[TB] FAIL backpressure fires: got %0d count %0d expected 6 count 0", fires, count); end
   endtask

   task automatic test_frame();
      logic [40:0] e, a;
      int nb, tl[$];
      flush();
      m_axis_tready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         int nv;
         nv = (pass == 0) ? 7 : 2;
         nb = 0; tl.delete();
         for (int cyc = 0; cyc < 200; cyc++) begin
            in_valid = (cyc < nv);
            if (cyc < nv) in_data = rand_vec();
            e = exp_outs(); a = act_outs(e[40]);
            checks++; if (a !== e) begin errors++; $display("[TB] FAIL frame p%0d cyc %0d: got %h expected %h", pass, cyc, a, e); end
            if (m_axis_tvalid && m_axis_tready) begin nb++; if (m_axis_tlast) tl.push_back(nb); end
            if (cyc >= nv && beats.size() == 0) break;
            step();
         end
         in_valid = 1'b0;
         if (pass == 0) begin
            checks++; if (nb != 42 || tl.size() != 2 || tl[0] != 18 || tl[1] != 36) begin
               errors++; $display("[TB] FAIL frame tlast 7 vectors: got %0d beats, %0d tlasts %p expected 42 beats, tlast at 18 36", nb, tl.size(), tl);
            end
         end else begin
            checks++; if (nb != 12 || tl.size() != 1 || tl[0] != 12) begin
               errors++; $display("[TB] FAIL frame continuation: got %0d beats, tlasts %p expected 12 beats, tlast at 12", nb, tl);
            end
         end
      end
   endtask

   task automatic test_fill();
      logic [40:0] e, a;
      int fires;
      flush();
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         in_valid = 1'b1; in_data = rand_vec();
         step();
         in_valid = 1'b0;
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL fill push %0d: got %h expected %h", i, a, e); end
         if (i == 11) begin checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill in_ready@11: got %b expected 1", in_ready); end end
         if (i == 12) begin checks++; if ({in_ready, count} !== {1'b0, CW'(12)}) begin errors++; $display("[TB] FAIL fill in_ready@12: got %b/%0d expected 0/12", in_ready, count); end end
         if (i == 16) begin checks++; if ({overflow, count} !== {1'b0, CW'(16)}) begin errors++; $display("[TB] FAIL fill full: got ovf %b count %0d expected 0/16", overflow, count); end end
         if (i == 17) begin checks++; if ({overflow, count} !== {1'b1, CW'(16)}) begin errors++; $display("[TB] FAIL fill drop: got ovf %b count %0d expected 1/16", overflow, count); end end
      end
      m_axis_tready = 1'b1; fires = 0;
      for (int cyc = 0; cyc < 200 && beats.size() != 0; cyc++) begin
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL fill drain cyc %0d: got %h expected %h", cyc, a, e); end
         if (m_axis_tvalid) fires++;
         step();
      end
      checks++; if (fires != 16 * LANES || count !== '0) begin errors++; $display("[TB] FAIL fill drain total: got %0d beats count %0d expected 96 count 0", fires, count); end
   endtask

   task automatic test_push_pop_full();
      logic [40:0] e, a;
      int fires;
      flush();
      m_axis_tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin in_valid = 1'b1; in_data = rand_vec(); step(); end
      in_valid = 1'b0; m_axis_tready = 1'b1;
      for (int i = 0; i < LANES - 1; i++) step();
      in_valid = 1'b1; in_data = rand_vec();
      step();
      in_valid = 1'b0;
      checks++; if ({count, overflow} !== {CW'(16), 1'b0}) begin errors++; $display("[TB] FAIL push+pop at full: got count %0d ovf %b expected 16/0", count, overflow); end
      fires = 0;
      for (int cyc = 0; cyc < 200 && beats.size() != 0; cyc++) begin
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL push+pop drain cyc %0d: got %h expected %h", cyc, a, e); end
         if (m_axis_tvalid) fires++;
         step();
      end
      checks++; if (fires != 16 * LANES) begin errors++; $display("[TB] FAIL push+pop drain total: got %0d beats expected 96", fires); end
   endtask

   // Abandons a vector after two beats, either with clear or an rstn pulse,
   // then checks that a fresh frame of FRAME_LEN vectors ends on beat 18.
   task automatic test_abort(input bit use_reset);
      logic [40:0] e, a;
      int nb, tl[$];
      m_axis_tready = 1'b1; in_valid = 1'b1; in_data = rand_vec();
      step();
      in_valid = 1'b0;
      step(); step();
      if (!use_reset) begin
         clear = 1'b1; in_valid = 1'b1; in_data = rand_vec();
         step();
         clear = 1'b0; in_valid = 1'b0;
      end else begin
         m_axis_tready = 1'b0;
         #2 rstn = 1'b0;
         #1;
         m_reset();
         @(negedge clk);
         rstn = 1'b1; m_axis_tready = 1'b1;
      end
      checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, count, overflow} !== '0) begin
         errors++; $display("[TB] FAIL abort rst%0d state: got v%b l%b %h count %0d ovf %b expected all 0", use_reset, m_axis_tvalid, m_axis_tlast, m_axis_tdata, count, overflow);
      end
      nb = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         in_valid = (cyc < FRAME_LEN);
         if (cyc < FRAME_LEN) in_data = rand_vec();
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL abort rst%0d cyc %0d: got %h expected %h", use_reset, cyc, a, e); end
         if (m_axis_tvalid && m_axis_tready) begin nb++; if (m_axis_tlast) tl.push_back(nb); end
         if (cyc >= FRAME_LEN && beats.size() == 0) break;
         step();
      end
      in_valid = 1'b0;
      checks++; if (nb != FRAME_LEN * LANES || tl.size() != 1 || tl[0] != 18) begin
         errors++; $display("[TB] FAIL abort rst%0d new frame: got %0d beats tlasts %p expected 18 beats tlast at 18", use_reset, nb, tl);
      end
   endtask

   task automatic test_random();
      logic [40:0] e, a;
      flush();
      for (int cyc = 0; cyc < 800; cyc++) begin
         in_valid      = ($urandom_range(2) == 0);
         in_data       = rand_vec();
         m_axis_tready = ($urandom_range(3) != 0);
         clear         = ($urandom_range(120) == 0);
         e = exp_outs(); a = act_outs(e[40]);
         checks++; if (a !== e) begin errors++; $display("[TB] FAIL random cyc %0d: got %h expected %h", cyc, a, e); end
         step();
      end
      clear = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      test_reset();
      test_single();
      test_backpressure();
      test_frame();
      test_fill();
      test_push_pop_full();
      test_abort(1'b0);
      test_abort(1'b1);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
